// File: rtl/tick_countdown_timer.sv
// BCD MM:SS countdown timer clocked by tick pulses, TICKS_PER_SEC ticks per decrement.
// Optional macro TICK_COUNTDOWN_AUTO_RELOAD_EN reloads the last valid load value on expiry.
module tick_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [7:0] i_load_mm,
  input  logic [7:0] i_load_ss,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [7:0] o_mm,
  output logic [7:0] o_ss,
  output logic [1:0] o_state,
  output logic       o_done,
  output logic       o_load_err
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam logic [9:0] PrescMax = 10'(TICKS_PER_SEC - 1);

  state_e     state_q, state_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic [9:0] presc_q, presc_d;
  logic       done_q, done_d;
  logic       load_err_q, load_err_d;
  logic       load_valid;
  logic [15:0] dec_val;

`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
  logic [7:0] shadow_mm_q, shadow_mm_d;
  logic [7:0] shadow_ss_q, shadow_ss_d;
`endif

  // One-second BCD decrement with borrows; caller guarantees a nonzero value.
  function automatic logic [15:0] bcd_dec(input logic [7:0] mm, input logic [7:0] ss);
    logic [7:0] m;
    logic [7:0] s;
    m = mm;
    s = ss;
    if (s[3:0] != 4'd0) begin
      s[3:0] = s[3:0] - 4'd1;
    end else if (s[7:4] != 4'd0) begin
      s[7:4] = s[7:4] - 4'd1;
      s[3:0] = 4'd9;
    end else begin
      s = 8'h59;
      if (m[3:0] != 4'd0) begin
        m[3:0] = m[3:0] - 4'd1;
      end else begin
        m[7:4] = m[7:4] - 4'd1;
        m[3:0] = 4'd9;
      end
    end
    return {m, s};
  endfunction

  assign dec_val = bcd_dec(mm_q, ss_q);

  assign load_valid = (i_load_mm[7:4] <= 4'd9) && (i_load_mm[3:0] <= 4'd9) &&
                      (i_load_ss[7:4] <= 4'd5) && (i_load_ss[3:0] <= 4'd9);

  always_comb begin
    state_d    = state_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
    shadow_mm_d = shadow_mm_q;
    shadow_ss_d = shadow_ss_q;
`endif
    // Strict priority: a higher-priority strobe consumes the cycle.
    if (i_load) begin
      if (load_valid) begin
        mm_d    = i_load_mm;
        ss_d    = i_load_ss;
        presc_d = 10'd0;
        state_d = StIdle;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
        shadow_mm_d = i_load_mm;
        shadow_ss_d = i_load_ss;
`endif
      end else begin
        load_err_d = 1'b1;
      end
    end else if (i_pause) begin
      if (state_q == StRunning) state_d = StPaused;
    end else if (i_start) begin
      if (state_q == StIdle && {mm_q, ss_q} != 16'h0000) begin
        state_d = StRunning;
        presc_d = 10'd0;
      end else if (state_q == StPaused) begin
        state_d = StRunning;
      end
    end else if (i_tick && state_q == StRunning) begin
      if (presc_q >= PrescMax) begin
        presc_d      = 10'd0;
        {mm_d, ss_d} = dec_val;
        if (dec_val == 16'h0000) begin
          done_d = 1'b1;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
          if ({shadow_mm_q, shadow_ss_q} != 16'h0000) begin
            mm_d = shadow_mm_q;
            ss_d = shadow_ss_q;
          end else begin
            state_d = StExpired;
          end
`else
          state_d = StExpired;
`endif
        end
      end else begin
        presc_d = presc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      presc_q    <= 10'd0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
      shadow_mm_q <= 8'h00;
      shadow_ss_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
      shadow_mm_q <= shadow_mm_d;
      shadow_ss_q <= shadow_ss_d;
`endif
    end
  end

  assign o_mm       = mm_q;
  assign o_ss       = ss_q;
  assign o_state    = state_q;
  assign o_done     = done_q;
  assign o_load_err = load_err_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Self-checking bench for tick_countdown_timer: directed plan steps, then random traffic
// compared each cycle against a total-seconds reference model.
module tb_tick_countdown_timer;

  localparam int unsigned Tps = 10;

  logic       clk = 1'b0;
  logic       rst, tick, load, start, pause;
  logic [7:0] lmm, lss;
  logic [7:0] o_mm, o_ss;
  logic [1:0] o_state;
  logic       o_done, o_load_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: value as total seconds, state 0..3, prescaler as plain count.
  int m_secs, m_state, m_presc, m_shadow;
  bit m_done, m_err;

  always #5 clk = ~clk;

  tick_countdown_timer #(.TICKS_PER_SEC(Tps)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_tick     (tick),
    .i_load     (load),
    .i_load_mm  (lmm),
    .i_load_ss  (lss),
    .i_start    (start),
    .i_pause    (pause),
    .o_mm       (o_mm),
    .o_ss       (o_ss),
    .o_state    (o_state),
    .o_done     (o_done),
    .o_load_err (o_load_err)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic t, input logic ld, input logic [7:0] mm,
                       input logic [7:0] ss, input logic st, input logic pa);
    m_done = 0;
    m_err  = 0;
    if (r) begin
      m_secs = 0; m_state = 0; m_presc = 0; m_shadow = 0;
    end else if (ld) begin
      if (mm[7:4] <= 9 && mm[3:0] <= 9 && ss[7:4] <= 5 && ss[3:0] <= 9) begin
        m_secs   = (int'(mm[7:4]) * 10 + int'(mm[3:0])) * 60 + int'(ss[7:4]) * 10 + int'(ss[3:0]);
        m_shadow = m_secs;
        m_state  = 0;
        m_presc  = 0;
      end else begin
        m_err = 1;
      end
    end else if (pa) begin
      if (m_state == 1) m_state = 2;
    end else if (st) begin
      if (m_state == 0 && m_secs != 0) begin
        m_state = 1;
        m_presc = 0;
      end else if (m_state == 2) begin
        m_state = 1;
      end
    end else if (t && m_state == 1) begin
      m_presc++;
      if (m_presc == Tps) begin
        m_presc = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_done = 1;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
          if (m_shadow != 0) m_secs = m_shadow;
          else m_state = 3;
`else
          m_state = 3;
`endif
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic ld, input logic [7:0] mm,
                     input logic [7:0] ss, input logic st, input logic pa);
    rst = r; tick = t; load = ld; lmm = mm; lss = ss; start = st; pause = pa;
    @(posedge clk);
    model(r, t, ld, mm, ss, st, pa);
    #1;
    check("mm", o_mm, to_bcd(m_secs / 60));
    check("ss", o_ss, to_bcd(m_secs % 60));
    check("state", {6'd0, o_state}, 8'(m_state));
    check("done", {7'd0, o_done}, {7'd0, m_done});
    check("load_err", {7'd0, o_load_err}, {7'd0, m_err});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0);
  endtask
  task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
    cyc(0, 0, 1, mm, ss, 0, 0);
  endtask
  task automatic do_start();
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 0);
  endtask
  task automatic do_pause();
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 1);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 8'h00, 8'h00, 0, 0);
      idle();
    end
  endtask

  initial begin
    m_secs = 0; m_state = 0; m_presc = 0; m_shadow = 0; m_done = 0; m_err = 0;
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0);
    cyc(1, 1, 1, 8'h12, 8'h34, 1, 0);
    check("reset_mm", o_mm, 8'h00);
    check("reset_state", {6'd0, o_state}, 8'd0);

    // 00:03 countdown to expiry
    do_load(8'h00, 8'h03);
    do_start();
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 1, 0, 8'h00, 8'h00, 0, 0);
      if (i == 10) check("ss_t10", o_ss, 8'h02);
      if (i == 20) check("ss_t20", o_ss, 8'h01);
      if (i == 30) begin
        check("done_t30", {7'd0, o_done}, 8'd1);
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
        check("reload_ss", o_ss, 8'h03);
        check("reload_state", {6'd0, o_state}, 8'd1);
`else
        check("expired_ss", o_ss, 8'h00);
        check("expired_state", {6'd0, o_state}, 8'd3);
`endif
      end
      idle();
    end
    check("done_off", {7'd0, o_done}, 8'd0);
    ticks(10);

    // Minute borrows
    do_load(8'h01, 8'h00);
    do_start();
    ticks(10);
    check("borrow_mm", o_mm, 8'h00);
    check("borrow_ss", o_ss, 8'h59);
    do_load(8'h10, 8'h00);
    do_start();
    ticks(10);
    check("borrow10_mm", o_mm, 8'h09);
    check("borrow10_ss", o_ss, 8'h59);

    // Pause keeps the partial second
    do_load(8'h00, 8'h05);
    do_start();
    ticks(4);
    do_pause();
    ticks(20);
    check("paused_ss", o_ss, 8'h05);
    do_start();
    ticks(5);
    check("resume5_ss", o_ss, 8'h05);
    ticks(1);
    check("resume6_ss", o_ss, 8'h04);

    // Invalid loads and zero start
    do_load(8'h1A, 8'h00);
    check("bad_mm_err", {7'd0, o_load_err}, 8'd1);
    check("bad_mm_keep", o_ss, 8'h04);
    idle();
    do_load(8'h00, 8'h60);
    check("bad_ss_err", {7'd0, o_load_err}, 8'd1);
    do_load(8'h00, 8'h00);
    do_start();
    check("zero_start", {6'd0, o_state}, 8'd0);

    // Load wins over start while running; reset mid-count
    do_load(8'h00, 8'h09);
    do_start();
    ticks(3);
    cyc(0, 1, 1, 8'h02, 8'h30, 1, 0);
    check("ld_start_state", {6'd0, o_state}, 8'd0);
    check("ld_start_mm", o_mm, 8'h02);
    do_start();
    ticks(12);
    cyc(1, 1, 0, 8'h00, 8'h00, 0, 0);
    check("rst_mid_ss", o_ss, 8'h00);

`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
    do_load(8'h00, 8'h02);
    do_start();
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 20; i++) begin
        cyc(0, 1, 0, 8'h00, 8'h00, 0, 0);
        if (i == 20) begin
          check("ar_done", {7'd0, o_done}, 8'd1);
          check("ar_ss", o_ss, 8'h02);
          check("ar_state", {6'd0, o_state}, 8'd1);
        end
        idle();
      end
    end
`endif

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      logic       r, t, ld, st, pa;
      logic [7:0] mm, ss;
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 59) == 0);
      pa = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 14) == 0);
      t  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 4) == 0) begin
        mm = 8'($urandom);
        ss = 8'($urandom);
      end else begin
        mm = to_bcd($urandom_range(0, 1));
        ss = to_bcd($urandom_range(0, 59));
      end
      cyc(r, t, ld, mm, ss, st, pa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
